video_tmds_encoder: RTL and testbench
=====================================

// Module: video_tmds_encoder
// PURPOSE
//  Downstream of the video compositor: takes its registered 12-bit RGB, DE and sync outputs and produces three 10-bit TMDS symbol streams (DVI 1.0 8b/10b with DC balance).
//  Feeds the serializer/OSERDES wrapper; runs in the pixel clock domain, one symbol per channel per clk.
// PARAMETERS
//  SYNC_INV        0  1: invert hsync/vsync before encoding into channel 0 control bits
//  SCANLINE_SHIFT  1  right-shift (1..3) applied to each 4-bit component on odd lines (only with VIDEO_TMDS_SCANLINES_EN)
// PORTS
//  clk            in   1   pixel clock
//  reset_n        in   1   asynchronous, active-low reset
//  video_r        in   4   red component (compositor output register)
//  video_g        in   4   green component
//  video_b        in   4   blue component
//  video_de       in   1   1 = active pixel, 0 = blanking
//  video_hsync    in   1   horizontal sync
//  video_vsync    in   1   vertical sync
//  video_oddline  in   1   1 = odd physical scanline (used only with VIDEO_TMDS_SCANLINES_EN)
//  tmds_ch0       out  10  blue channel symbol; carries {vsync,hsync} in blanking
//  tmds_ch1       out  10  green channel symbol
//  tmds_ch2       out  10  red channel symbol
//  tmds_de        out  1   DE delayed to align with the symbols
// BEHAVIOUR
//  - Pipeline: S1 registers inputs, expands each 4-bit component c to 8 bits {c,c}; S2 computes q_m[8:0] and n1(q_m[7:0]); S3 applies DC balance, registers the symbols. Latency 3 clk, input to tmds_*; tmds_de equals video_de delayed 3 clk.
//  - Reset (async, reset_n=0): all pipeline regs 0; tmds_ch0/1/2 = 10'h354 (control 00); tmds_de = 0; disparity counters = 0. Release: first encoded symbol 3 clk after first sampled input.
//  - Transition minimisation (per channel, d = 8-bit data, N1 = ones in d):
//    use XNOR if N1>4 or (N1==4 and d[0]==0), else XOR; q_m[0]=d[0], q_m[i]=q_m[i-1] op d[i]; q_m[8] = 1 for XOR, 0 for XNOR.
//  - DC balance: signed 5-bit cnt per channel, n1/n0 = ones/zeros in q_m[7:0]:
//    cnt==0 or n1==n0: out={~q_m8, q_m8, q_m8 ? q_m : ~q_m}; cnt += q_m8 ? n1-n0 : n0-n1.
//    (cnt>0 and n1>n0) or (cnt<0 and n0>n1): out={1, q_m8, ~q_m}; cnt += 2*q_m8 + n0-n1.
//    otherwise: out={0, q_m8, q_m}; cnt += n1-n0 - 2*(~q_m8).
//    cnt stays within -8..+8; 5-bit two's complement is sufficient.
//  - Blanking (S3 de=0): cnt forced to 0; ch1 = ch2 = 10'h354.
//    ch0 = symbol for {c1,c0} = {vsync^SYNC_INV, hsync^SYNC_INV}: 00=10'h354, 01=10'h0AB, 10=10'h154, 11=10'h2AB.
//  - Each channel keeps its own independent cnt; DE and syncs stay aligned with their pixel through all stages.
//  - Every DE transition takes effect on the exact symbol of the pixel that carries it; a 1-clk DE pulse yields exactly one data symbol.
//  - Reset mid-line: outputs drop immediately to 10'h354 / tmds_de = 0; encoding resumes from cnt = 0.
// CONFIGURATION
//  VIDEO_TMDS_SCANLINES_EN defined: in S1, when video_oddline = 1, each component c -> c >> SCANLINE_SHIFT before expansion; sync and DE unaffected.
//  Not defined: video_oddline ignored (port kept, unconnected internally), components encoded unmodified.
// TESTING
//  1. Reset held, then released, DE=0, h=v=0, SYNC_INV=0 -> all channels 10'h354; tmds_de=0.
//  2. DE=1, RGB=12'h000 for 3 clks after blanking -> ch0 symbols 10'h100, 10'h3FF, 10'h100 (cnt -8, +2, -6), from 3 clk after the first input.
//  3. DE=1, RGB=12'hFFF, single pixel after blanking -> each channel 10'h200; cnt becomes -8; next blank returns cnt to 0.
//  4. DE=0: {v,h} stepped 00,01,10,11 -> ch0 = 10'h354, 10'h0AB, 10'h154, 10'h2AB, each 3 clk later; ch1/ch2 stay 10'h354. SYNC_INV=1 gives the reverse order.
//  5. Random RGB over 640 px: decode each symbol with a reference 10b/8b model -> data matches input; running disparity stays within -8..+8; tmds_de = DE delayed 3 clk.
//  6. With VIDEO_TMDS_SCANLINES_EN, SCANLINE_SHIFT=1, oddline=1, RGB=12'hF00 -> ch2 decodes 8'h77; oddline=0 -> 8'hFF.
//     Without the macro: 8'hFF in both cases.

Source files
------------

// File: rtl/video_tmds_encoder.sv
// video_tmds_encoder: 3-stage DVI 8b/10b TMDS encoder for 4-bit RGB.
// Build option: define VIDEO_TMDS_SCANLINES_EN to dim odd scanlines.
module video_tmds_encoder #(
    parameter int SYNC_INV       = 0,
    parameter int SCANLINE_SHIFT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] video_r,
    input  logic [3:0] video_g,
    input  logic [3:0] video_b,
    input  logic       video_de,
    input  logic       video_hsync,
    input  logic       video_vsync,
    input  logic       video_oddline,
    output logic [9:0] tmds_ch0,
    output logic [9:0] tmds_ch1,
    output logic [9:0] tmds_ch2,
    output logic       tmds_de
);

    localparam logic [9:0] CTL_00 = 10'h354;
    localparam logic [9:0] CTL_01 = 10'h0AB;
    localparam logic [9:0] CTL_10 = 10'h154;
    localparam logic [9:0] CTL_11 = 10'h2AB;
    localparam logic       INV    = (SYNC_INV != 0);

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    // Transition-minimised word; bit 8 set means XOR chain.
    function automatic logic [8:0] tmin(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n;
        logic       use_xnor;
        n        = ones8(d);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Returns {next_cnt[4:0], symbol[9:0]}.
    function automatic logic [14:0] balance(
        input logic [8:0]        qm,
        input logic [3:0]        n1,
        input logic signed [4:0] cnt
    );
        logic signed [4:0] diff;
        logic signed [4:0] nc;
        logic [9:0]        sym;
        // diff = n1 - n0 = 2*n1 - 8
        diff = $signed({n1, 1'b0}) - 5'sd8;
        if (cnt == 5'sd0 || diff == 5'sd0) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            nc  = qm[8] ? cnt + diff : cnt - diff;
        end else if ((cnt > 5'sd0 && diff > 5'sd0) ||
                     (cnt < 5'sd0 && diff < 5'sd0)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nc  = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nc  = cnt + diff - (qm[8] ? 5'sd0 : 5'sd2);
        end
        return {nc, sym};
    endfunction

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        logic [9:0] s;
        unique case (c)
            2'b00:   s = CTL_00;
            2'b01:   s = CTL_01;
            2'b10:   s = CTL_10;
            default: s = CTL_11;
        endcase
        return s;
    endfunction

    logic [3:0] comp_r;
    logic [3:0] comp_g;
    logic [3:0] comp_b;

`ifdef VIDEO_TMDS_SCANLINES_EN
    // Darken every component on odd scanlines before expansion.
    always_comb begin
        comp_r = video_r;
        comp_g = video_g;
        comp_b = video_b;
        if (video_oddline) begin
            comp_r = video_r >> SCANLINE_SHIFT;
            comp_g = video_g >> SCANLINE_SHIFT;
            comp_b = video_b >> SCANLINE_SHIFT;
        end
    end
`else
    logic unused_oddline;
    assign unused_oddline = video_oddline;
    assign comp_r = video_r;
    assign comp_g = video_g;
    assign comp_b = video_b;
`endif

    // Stage 1: channel order is 0 = blue, 1 = green, 2 = red.
    logic [7:0] s1_d [3];
    logic       s1_de;
    logic       s1_hs;
    logic       s1_vs;

    // Stage 1: register inputs with 4->8 bit replication.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 3; c++) begin
                s1_d[c] <= '0;
            end
            s1_de <= 1'b0;
            s1_hs <= 1'b0;
            s1_vs <= 1'b0;
        end else begin
            s1_d[0] <= {comp_b, comp_b};
            s1_d[1] <= {comp_g, comp_g};
            s1_d[2] <= {comp_r, comp_r};
            s1_de   <= video_de;
            s1_hs   <= video_hsync;
            s1_vs   <= video_vsync;
        end
    end

    logic [8:0] s2_qm [3];
    logic [3:0] s2_n1 [3];
    logic       s2_de;
    logic       s2_hs;
    logic       s2_vs;
    logic [8:0] qm_c  [3];

    // Stage 2 logic: transition minimisation per channel.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            qm_c[c] = tmin(s1_d[c]);
        end
    end

    // Stage 2: register q_m and its ones count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 3; c++) begin
                s2_qm[c] <= '0;
                s2_n1[c] <= '0;
            end
            s2_de <= 1'b0;
            s2_hs <= 1'b0;
            s2_vs <= 1'b0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                s2_qm[c] <= qm_c[c];
                s2_n1[c] <= ones8(qm_c[c][7:0]);
            end
            s2_de <= s1_de;
            s2_hs <= s1_hs;
            s2_vs <= s1_vs;
        end
    end

    logic signed [4:0] cnt [3];
    logic [14:0]       bal [3];
    logic [1:0]        ctl;

    assign ctl = {s2_vs, s2_hs} ^ {INV, INV};

    // Stage 3 logic: DC balance against each channel's running count.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            bal[c] = balance(s2_qm[c], s2_n1[c], cnt[c]);
        end
    end

    // Stage 3: register symbols; blanking sends control and clears counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmds_ch0 <= CTL_00;
            tmds_ch1 <= CTL_00;
            tmds_ch2 <= CTL_00;
            tmds_de  <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            tmds_de <= s2_de;
            if (s2_de) begin
                tmds_ch0 <= bal[0][9:0];
                tmds_ch1 <= bal[1][9:0];
                tmds_ch2 <= bal[2][9:0];
                for (int c = 0; c < 3; c++) begin
                    cnt[c] <= $signed(bal[c][14:10]);
                end
            end else begin
                tmds_ch0 <= ctl_sym(ctl);
                tmds_ch1 <= CTL_00;
                tmds_ch2 <= CTL_00;
                for (int c = 0; c < 3; c++) begin
                    cnt[c] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_tmds_encoder.sv
// tb_video_tmds_encoder: scoreboard bench for video_tmds_encoder.
// Data symbols are decoded with a 10b/8b reference and compared to input.
module tb_video_tmds_encoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] video_r;
    logic [3:0] video_g;
    logic [3:0] video_b;
    logic       video_de;
    logic       video_hsync;
    logic       video_vsync;
    logic       video_oddline;
    logic [9:0] ch0, ch1, ch2;
    logic [9:0] ich0, ich1, ich2;
    logic       tde, itde;

    video_tmds_encoder #(.SYNC_INV(0), .SCANLINE_SHIFT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .video_r(video_r), .video_g(video_g), .video_b(video_b),
        .video_de(video_de), .video_hsync(video_hsync),
        .video_vsync(video_vsync), .video_oddline(video_oddline),
        .tmds_ch0(ch0), .tmds_ch1(ch1), .tmds_ch2(ch2),
        .tmds_de(tde)
    );

    video_tmds_encoder #(.SYNC_INV(1), .SCANLINE_SHIFT(1)) dut_inv (
        .clk(clk), .reset_n(reset_n),
        .video_r(video_r), .video_g(video_g), .video_b(video_b),
        .video_de(video_de), .video_hsync(video_hsync),
        .video_vsync(video_vsync), .video_oddline(video_oddline),
        .tmds_ch0(ich0), .tmds_ch1(ich1), .tmds_ch2(ich2),
        .tmds_de(itde)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       de;
        logic [1:0] vh;
        logic [7:0] d [3];
        logic       exact;
        logic [9:0] sym;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   disp [3] = '{0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] d, o;
        d    = s[9] ? ~s[7:0] : s[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    function automatic int bal10(input logic [9:0] s);
        int n = 0;
        for (int i = 0; i < 10; i++) n += s[i] ? 1 : -1;
        return n;
    endfunction

    function automatic logic [9:0] csym(input logic [1:0] vh);
        case (vh)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    function automatic logic [7:0] exp8(input logic [3:0] c,
                                        input logic odd);
        logic [3:0] v;
        v = c;
`ifdef VIDEO_TMDS_SCANLINES_EN
        if (odd) v = c >> 1;
`else
        if (odd) v = c;
`endif
        return {v, v};
    endfunction

    task automatic compare(input exp_t e);
        logic [9:0] s [3];
        s = '{ch0, ch1, ch2};
        chk("de", {31'd0, tde}, {31'd0, e.de});
        chk("de_inv", {31'd0, itde}, {31'd0, e.de});
        if (e.de) begin
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("dec%0d", c), {24'd0, dec(s[c])},
                    {24'd0, e.d[c]});
                disp[c] += bal10(s[c]);
                chk($sformatf("disp%0d", c),
                    {31'd0, (disp[c] >= -8 && disp[c] <= 8)}, 32'd1);
                if (e.exact)
                    chk($sformatf("sym%0d", c), {22'd0, s[c]},
                        {22'd0, e.sym});
            end
        end else begin
            disp = '{0, 0, 0};
            chk("ctl0", {22'd0, ch0}, {22'd0, csym(e.vh)});
            chk("ctl1", {22'd0, ch1}, 32'h354);
            chk("ctl2", {22'd0, ch2}, 32'h354);
            chk("ctl0_inv", {22'd0, ich0}, {22'd0, csym(~e.vh)});
        end
    endtask

    task automatic step(input logic de, input logic [1:0] vh,
                        input logic [11:0] rgb, input logic odd,
                        input logic exact, input logic [9:0] sym);
        exp_t e;
        @(negedge clk);
        if (sb.size() == 3) compare(sb.pop_front());
        video_de = de;
        {video_vsync, video_hsync} = vh;
        {video_r, video_g, video_b} = rgb;
        video_oddline = odd;
        e.de    = de;
        e.vh    = vh;
        e.d[0]  = exp8(rgb[3:0], odd);
        e.d[1]  = exp8(rgb[7:4], odd);
        e.d[2]  = exp8(rgb[11:8], odd);
        e.exact = exact;
        e.sym   = sym;
        sb.push_back(e);
    endtask

    task automatic blank(input int n, input logic [1:0] vh);
        for (int i = 0; i < n; i++) step(1'b0, vh, 12'h0, 1'b0, 1'b0, 10'h0);
    endtask

    task automatic zero_run();
        step(1'b1, 2'b00, 12'h000, 1'b0, 1'b1, 10'h100);
        step(1'b1, 2'b00, 12'h000, 1'b0, 1'b1, 10'h3FF);
        step(1'b1, 2'b00, 12'h000, 1'b0, 1'b1, 10'h100);
    endtask

    initial begin
        reset_n = 1'b0;
        {video_r, video_g, video_b} = 12'h0;
        video_de = 1'b0;
        video_hsync = 1'b0;
        video_vsync = 1'b0;
        video_oddline = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ch0", {22'd0, ch0}, 32'h354);
        chk("rst_ch1", {22'd0, ch1}, 32'h354);
        chk("rst_ch2", {22'd0, ch2}, 32'h354);
        chk("rst_de", {31'd0, tde}, 32'd0);
        reset_n = 1'b1;

        blank(4, 2'b00);
        blank(2, 2'b01);
        blank(2, 2'b10);
        blank(2, 2'b11);
        blank(2, 2'b00);

        zero_run();
        blank(2, 2'b00);

        step(1'b1, 2'b00, 12'hFFF, 1'b0, 1'b1, 10'h200);
        blank(1, 2'b01);
        step(1'b1, 2'b00, 12'hFFF, 1'b0, 1'b1, 10'h200);
        blank(2, 2'b00);

        step(1'b1, 2'b00, 12'hF00, 1'b1, 1'b0, 10'h0);
        step(1'b1, 2'b00, 12'hF00, 1'b0, 1'b0, 10'h0);
        step(1'b1, 2'b00, 12'hF00, 1'b1, 1'b0, 10'h0);
        blank(2, 2'b00);

        for (int i = 0; i < 640; i++) begin
            logic d;
            d = ($urandom_range(0, 9) != 0);
            step(d, 2'($urandom_range(0, 3)), 12'($urandom),
                 1'($urandom_range(0, 1)), 1'b0, 10'h0);
        end
        blank(2, 2'b00);

        for (int i = 0; i < 8; i++)
            step(1'b1, 2'b00, 12'($urandom), 1'b0, 1'b0, 10'h0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_ch0", {22'd0, ch0}, 32'h354);
        chk("mid_ch1", {22'd0, ch1}, 32'h354);
        chk("mid_ch2", {22'd0, ch2}, 32'h354);
        chk("mid_de", {31'd0, tde}, 32'd0);
        sb.delete();
        disp = '{0, 0, 0};
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        zero_run();
        blank(6, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
